// File: rtl/flag_rom_axil_slave.sv
// AXI4-Lite register slave for the FlagUPDOWN game: CTRL, IDX, SCRATCH and a
// read-only DATA window onto a fixed flag-pattern ROM with optional auto-increment.
module flag_rom_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int ROM_DEPTH          = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready
);

  localparam int IW = $clog2(ROM_DEPTH);
  localparam logic [1:0] SEL_CTRL    = 2'd0;
  localparam logic [1:0] SEL_IDX     = 2'd1;
  localparam logic [1:0] SEL_DATA    = 2'd2;
  localparam logic [1:0] SEL_SCRATCH = 2'd3;

  // Handshake semantics: a transfer happens on every rising edge where valid
  // and ready are both 1; valid is held by the source until that edge.
  logic          aw_captured;
  logic          w_captured;
  logic [1:0]    aw_sel;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          autoinc;
  logic [IW-1:0] idx;
  logic [31:0]   scratch;
  logic [31:0]   rd_mux;
  logic [7:0]    idx8;
  logic          wr_fire;
  logic          ar_fire;
  logic          unused_inputs;

  assign wr_fire       = aw_captured && w_captured;
  assign ar_fire       = s00_axi_arvalid && s00_axi_arready;
  assign s00_axi_rresp = 2'b00;
  assign idx8          = 8'(idx);
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  always_comb begin
    rd_mux = '0;
    case (s00_axi_araddr[3:2])
      SEL_CTRL:    rd_mux = {31'd0, autoinc};
      SEL_IDX:     rd_mux = 32'(idx);
      SEL_DATA:    rd_mux = {16'hF1A6, idx8, idx8[3:0], ~idx8[3:0]};
      SEL_SCRATCH: rd_mux = scratch;
      default:     rd_mux = '0;
    endcase
  end

  // Write address/data capture and response generation.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= 2'b00;
      aw_captured     <= 1'b0;
      w_captured      <= 1'b0;
      aw_sel          <= 2'd0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
    end else begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      if (s00_axi_awvalid && !aw_captured && !s00_axi_bvalid && !s00_axi_awready)
        s00_axi_awready <= 1'b1;
      if (s00_axi_wvalid && !w_captured && !s00_axi_bvalid && !s00_axi_wready)
        s00_axi_wready <= 1'b1;
      if (s00_axi_awvalid && s00_axi_awready) begin
        aw_captured <= 1'b1;
        aw_sel      <= s00_axi_awaddr[3:2];
      end
      if (s00_axi_wvalid && s00_axi_wready) begin
        w_captured <= 1'b1;
        wdata_q    <= s00_axi_wdata[31:0];
        wstrb_q    <= s00_axi_wstrb[3:0];
      end
      if (wr_fire) begin
        aw_captured    <= 1'b0;
        w_captured     <= 1'b0;
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= (aw_sel == SEL_DATA) ? 2'b10 : 2'b00;
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: one outstanding read, data registered at AR acceptance.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_arready <= 1'b0;
      if (s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_arready)
        s00_axi_arready <= 1'b1;
      if (ar_fire) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= C_S_AXI_DATA_WIDTH'(rd_mux);
      end else if (s00_axi_rvalid && s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  // Register file; the write to IDX is placed last so it beats the auto-increment.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      autoinc <= 1'b0;
      idx     <= '0;
      scratch <= '0;
    end else begin
      if (ar_fire && s00_axi_araddr[3:2] == SEL_DATA && autoinc)
        idx <= idx + 1'b1;
      if (wr_fire) begin
        case (aw_sel)
          SEL_CTRL: if (wstrb_q[0]) autoinc <= wdata_q[0];
          SEL_IDX:  if (wstrb_q[0]) idx <= wdata_q[IW-1:0];
          SEL_SCRATCH: begin
            for (int b = 0; b < 4; b++)
              if (wstrb_q[b]) scratch[8*b +: 8] <= wdata_q[8*b +: 8];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
